// File: rtl/uart_cmd_pkg.sv
// Shared opcode and command-byte constants, FSM encoding and command-byte builder
// for the display command scheduler.
package uart_cmd_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SHOW  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [7:0] CMD_CLEAR   = 8'h10;
  localparam logic [3:0] CMD_LOAD_HI = 4'h2;
  localparam logic [7:0] CMD_SHOW    = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  function automatic logic [7:0] build_cmd(input logic [1:0] op, input logic [3:0] data);
    case (op)
      OP_CLEAR: return CMD_CLEAR;
      OP_LOAD:  return {CMD_LOAD_HI, data};
      default:  return CMD_SHOW;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_serializer.sv
// Byte shift register plus tick/bit counters; reports o_done on the last clock of the
// phase the scheduler is in. i_load latches a new byte and clears both counters.
module uart_bit_serializer
  import uart_cmd_pkg::*;
#(
  parameter int BIT_TICKS = 2,
  parameter int GAP_TICKS = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  state_t     i_state,
  output logic       o_bit,
  output logic       o_done
);

  localparam int MAX_TICKS = (BIT_TICKS > GAP_TICKS) ? BIT_TICKS : GAP_TICKS;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);

  logic [TW-1:0] r_tick;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          w_bit_end;

  assign w_bit_end = (r_tick == BIT_LAST);
  assign o_bit     = r_shift[0];

  always_comb begin
    o_done = 1'b0;
    case (i_state)
      ST_START, ST_STOP: o_done = w_bit_end;
      ST_DATA:           o_done = w_bit_end && (r_idx == 3'd7);
      ST_GAP:            o_done = (r_tick == GAP_LAST);
      default:           o_done = 1'b0;
    endcase
  end

  // Counters clear on every phase change, so each phase counts from zero.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tick  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_load) begin
      r_shift <= i_byte;
      r_tick  <= '0;
      r_idx   <= '0;
    end else if (i_state != ST_IDLE) begin
      if (o_done) begin
        r_tick <= '0;
        r_idx  <= '0;
      end else if (i_state == ST_DATA && w_bit_end) begin
        r_tick  <= '0;
        r_idx   <= r_idx + 3'd1;
        r_shift <= {1'b0, r_shift[7:1]};
      end else begin
        r_tick <= r_tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Round-robin scheduler framing display commands for two requesters onto one serial line.
// UART_CMD_AUTO_SHOW_EN: a load frame is followed by an automatic show frame after its gap.
module uart_cmd_scheduler
  import uart_cmd_pkg::*;
#(
  parameter int BIT_TICKS = 2,
  parameter int GAP_TICKS = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic [1:0] i_op0,
  input  logic [3:0] i_data0,
  input  logic [1:0] i_op1,
  input  logic [3:0] i_data1,
  output logic [1:0] o_gnt,
  output logic       o_busy,
  output logic       o_serial
);

  state_t     r_state;
  logic       r_ptr;
`ifdef UART_CMD_AUTO_SHOW_EN
  logic       r_auto;
`endif
  logic       w_accept;
  logic       w_win;
  logic [1:0] w_op;
  logic [3:0] w_data;
  logic [7:0] w_byte;
  logic       w_load;
  logic       w_done;
  logic       w_bit;

  always_comb begin
    w_accept = (r_state == ST_IDLE) && (|i_req);
    w_win    = (i_req == 2'b11) ? r_ptr : i_req[1];
    w_op     = w_win ? i_op1 : i_op0;
    w_data   = w_win ? i_data1 : i_data0;
    w_byte   = build_cmd(w_op, w_data);
    w_load   = w_accept && (w_op != OP_RSVD);
    o_gnt    = 2'b00;
    if (w_accept) o_gnt = w_win ? 2'b10 : 2'b01;
`ifdef UART_CMD_AUTO_SHOW_EN
    if (r_state == ST_GAP && w_done && r_auto) begin
      w_byte = CMD_SHOW;
      w_load = 1'b1;
    end
`endif
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_serial = (r_state == ST_START) ? 1'b0 :
                    (r_state == ST_DATA)  ? w_bit : 1'b1;

  uart_bit_serializer #(
    .BIT_TICKS(BIT_TICKS),
    .GAP_TICKS(GAP_TICKS)
  ) u_ser (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_load (w_load),
    .i_byte (w_byte),
    .i_state(r_state),
    .o_bit  (w_bit),
    .o_done (w_done)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
`ifdef UART_CMD_AUTO_SHOW_EN
      r_auto  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Reserved opcodes are granted and rotate the pointer but send nothing.
          if (w_accept) begin
            r_ptr <= ~w_win;
            if (w_load) r_state <= ST_START;
`ifdef UART_CMD_AUTO_SHOW_EN
            r_auto <= (w_op == OP_LOAD);
`endif
          end
        end
        ST_START: if (w_done) r_state <= ST_DATA;
        ST_DATA:  if (w_done) r_state <= ST_STOP;
        ST_STOP:  if (w_done) r_state <= ST_GAP;
        ST_GAP: begin
          if (w_done) begin
`ifdef UART_CMD_AUTO_SHOW_EN
            if (r_auto) begin
              r_state <= ST_START;
              r_auto  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench: expected bytes are queued at each grant and matched against frames
// decoded from the serial line; cycle-exact waveform, arbitration and reset checks.
module tb_uart_cmd_scheduler;

  localparam int BT    = 2;
  localparam int GT    = 8;
  localparam int FRAME = 10 * BT + GT;
`ifdef UART_CMD_AUTO_SHOW_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op0 = 2'b00;
  logic [1:0] op1 = 2'b00;
  logic [3:0] d0  = 4'h0;
  logic [3:0] d1  = 4'h0;
  logic [1:0] gnt;
  logic       busy;
  logic       serial;

  int         total = 0;
  int         bad = 0;
  int         frames_rx = 0;
  int         frames_exp = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_scheduler #(
    .BIT_TICKS(BT),
    .GAP_TICKS(GT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_req   (req),
    .i_op0   (op0),
    .i_data0 (d0),
    .i_op1   (op1),
    .i_data1 (d1),
    .o_gnt   (gnt),
    .o_busy  (busy),
    .o_serial(serial)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
    frames_exp++;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, {31'd0, busy === 1'b0}, 32'd1);
  endtask

  function automatic logic exp_wave(input logic [7:0] b, input int c);
    int j;
    j = c / BT;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  // Serial-line receiver: decodes frames, checks framing and gap, pops the scoreboard.
  initial begin : mon
    logic [9:0] f;
    logic       ok;
    logic       gap_ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || serial !== 1'b0) continue;
      ok = 1'b1;
      aborted = 1'b0;
      f = '0;
      for (int c = 0; c < 10 * BT; c++) begin
        if (c > 0) @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        if (c % BT == 0) f[c/BT] = serial;
        else if (serial !== f[c/BT]) ok = 1'b0;
      end
      if (!aborted) begin
        frames_rx++;
        check("bit_stable", {31'd0, ok}, 32'd1);
        check("start_stop", {30'd0, f[9], f[0]}, 32'd2);
        if (exp_q.size() == 0) check("frame_expected", exp_q.size(), 32'd1);
        else check("frame_byte", {24'd0, f[8:1]}, {24'd0, exp_q.pop_front()});
        gap_ok = 1'b1;
        for (int g = 0; g < GT; g++) begin
          @(negedge clk);
          if (rst !== 1'b0) break;
          if (serial !== 1'b1) gap_ok = 1'b0;
        end
        check("gap_idle", {31'd0, gap_ok}, 32'd1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // 1: reset state, during and after reset
    #12;
    check("rst_serial", {31'd0, serial}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_serial", {31'd0, serial}, 32'd1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_gnt", {30'd0, gnt}, 32'd0);

    // 2: load A, cycle-exact waveform of 8'h2A frame plus gap
    op0 = 2'b01; d0 = 4'hA; req = 2'b01;
    #1;
    check("t2_gnt", {30'd0, gnt}, 32'd1);
    check("t2_busy_at_gnt", {31'd0, busy}, 32'd0);
    expect_byte(8'h2A);
    for (int c = 0; c < FRAME; c++) begin
      tick();
      if (c == 0) begin
        req = 2'b00;
        #1;
        check("t2_gnt_pulse", {30'd0, gnt}, 32'd0);
      end
      check($sformatf("t2_serial_c%0d", c), {31'd0, serial}, {31'd0, exp_wave(8'h2A, c)});
      check($sformatf("t2_busy_c%0d", c), {31'd0, busy}, 32'd1);
    end
    tick();
    check("t2_busy_end", {31'd0, busy}, 32'd0);
    check("t2_serial_end", {31'd0, serial}, 32'd1);

    // 3: round robin from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    op0 = 2'b10; op1 = 2'b00; req = 2'b11;
    #1;
    check("t3_gnt_first", {30'd0, gnt}, 32'd1);
    expect_byte(8'h40);
    tick();
    req = 2'b10;
    wait_idle(FRAME + 4, "t3a");
    check("t3_gnt_second", {30'd0, gnt}, 32'd2);
    expect_byte(8'h10);
    tick();
    req = 2'b00;
    wait_idle(FRAME + 4, "t3b");
    req = 2'b11;
    #1;
    check("t3_gnt_third", {30'd0, gnt}, 32'd1);
    expect_byte(8'h40);
    tick();
    req = 2'b00;
    wait_idle(FRAME + 4, "t3c");

    // 4: clear opcode, reserved opcode (grant, no frame, pointer moves)
    op0 = 2'b00; req = 2'b01;
    #1;
    check("t4_gnt_clear", {30'd0, gnt}, 32'd1);
    expect_byte(8'h10);
    tick();
    req = 2'b00;
    wait_idle(FRAME + 4, "t4a");
    op1 = 2'b11; req = 2'b10;
    #1;
    check("t4_gnt_rsvd", {30'd0, gnt}, 32'd2);
    tick();
    req = 2'b00;
    #1;
    check("t4_rsvd_gnt_low", {30'd0, gnt}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4_rsvd_busy_%0d", c), {31'd0, busy}, 32'd0);
      check($sformatf("t4_rsvd_serial_%0d", c), {31'd0, serial}, 32'd1);
      tick();
    end
    op0 = 2'b10; req = 2'b11;
    #1;
    check("t4_ptr_after_rsvd", {30'd0, gnt}, 32'd1);
    expect_byte(8'h40);
    tick();
    req = 2'b00;
    wait_idle(FRAME + 4, "t4b");

    // 5: reset during data bit 3, then a fresh frame
    op0 = 2'b01; d0 = 4'h4; req = 2'b01;
    #1;
    check("t5_gnt", {30'd0, gnt}, 32'd1);
    expect_byte(8'h24);
    tick();
    req = 2'b00;
    repeat (8) tick();
    check("t5_bit3_low", {31'd0, serial}, 32'd0);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_serial", {31'd0, serial}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_gnt", {30'd0, gnt}, 32'd0);
    void'(exp_q.pop_back());
    frames_exp--;
    tick();
    tick();
    rst = 1'b0;
    tick();
    op0 = 2'b10; req = 2'b01;
    #1;
    check("t5_gnt_fresh", {30'd0, gnt}, 32'd1);
    expect_byte(8'h40);
    tick();
    req = 2'b00;
    check("t5_fresh_start0", {31'd0, serial}, 32'd0);
    tick();
    check("t5_fresh_start1", {31'd0, serial}, 32'd0);
    wait_idle(FRAME + 4, "t5");

    // 6: load 5, optional automatic show frame
    op0 = 2'b01; d0 = 4'h5; req = 2'b01;
    #1;
    check("t6_gnt", {30'd0, gnt}, 32'd1);
    expect_byte(8'h25);
    if (AUTO) expect_byte(8'h40);
    tick();
    req = 2'b00;
    repeat (FRAME - 1) tick();
    check("t6_busy_last_gap", {31'd0, busy}, 32'd1);
    tick();
    check("t6_busy_after_frame", {31'd0, busy}, {31'd0, AUTO});
    check("t6_no_gnt", {30'd0, gnt}, 32'd0);
    wait_idle(FRAME + 4, "t6");

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    check("frame_count", frames_rx, frames_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
